// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: steers an input stream into one of two independent FIFO-buffered output channels.
`timescale 1ns/1ps
module demux_1to2_stream_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             full,
   output logic [7:0]       count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp, rp;
   logic             pop;
   // pointers carry one extra wrap bit to tell full from empty
   assign valid = wp != rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = valid && pop_ready;
   assign data  = mem[rp[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wp[AW-1:0]] <= wdata;
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp    <= rp + 1'b1;
            count <= count + 8'd1;
         end
      end
endmodule

module demux_1to2_stream #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [7:0]       a_count,
   output logic [WIDTH-1:0] b_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [7:0]       b_count
);
   logic a_full, b_full, a_push, b_push;
   // readiness follows only the selected FIFO's registered fullness, so a full target blocks the stream
   assign in_ready = in_sel ? !b_full : !a_full;
   assign a_push   = in_valid && in_ready && !in_sel;
   assign b_push   = in_valid && in_ready && in_sel;
   demux_1to2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_a (
      .clk(clk), .rst_n(rst_n), .push(a_push), .wdata(in_data), .pop_ready(a_ready),
      .data(a_data), .valid(a_valid), .full(a_full), .count(a_count)
   );
   demux_1to2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_b (
      .clk(clk), .rst_n(rst_n), .push(b_push), .wdata(in_data), .pop_ready(b_ready),
      .data(b_data), .valid(b_valid), .full(b_full), .count(b_count)
   );
endmodule
